mem_arbiter: RTL and testbench

Shares the CPU's single byte-wide synchronous RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM stage). It serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or splits the 32-bit data little-endian. It returns a one-cycle ready pulse to the requester it granted. It sits between the IF/MEM pipeline stages and the RAM, and is the block whose ready signals drive pipeline stalls.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : IF/MEM requester and byte-wide RAM port bundle
// Rev 1.0
// ============================================================================
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_rdy;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_rdy, if_data, mem_rdy, mem_rdata, ram_a, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_rdy, if_data, mem_rdy, mem_rdata, ram_a, ram_wr, ram_dout
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fixed-priority IF/MEM arbiter onto a byte-wide sync RAM
// Rev 1.0
// ============================================================================
module mem_arbiter (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state,     w_state_n;
  logic        r_owner_mem, w_owner_mem_n;
  logic [31:0] r_base,      w_base_n;
  logic [2:0]  r_len,       w_len_n;
  logic [31:0] r_wdata,     w_wdata_n;
  logic [2:0]  r_k,         w_k_n;
  logic [31:0] r_buf,       w_buf_n;
  logic [31:0] r_if_data,   w_if_data_n;
  logic [31:0] r_mem_rdata, w_mem_rdata_n;
  logic        r_if_rdy,    w_if_rdy_n;
  logic        r_mem_rdy,   w_mem_rdy_n;
  logic [31:0] r_ram_a,     w_ram_a_n;
  logic        r_ram_wr,    w_ram_wr_n;
  logic [7:0]  r_ram_dout,  w_ram_dout_n;

  logic [2:0]  w_k_inc;
  logic [1:0]  w_cap_idx;
  logic [2:0]  w_mem_len;

  assign w_k_inc   = r_k + 3'd1;
  assign w_cap_idx = r_k[1:0] - 2'd1;
  assign w_mem_len = (bus.mem_size == 2'd0) ? 3'd1 :
                     (bus.mem_size == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    w_state_n     = r_state;
    w_owner_mem_n = r_owner_mem;
    w_base_n      = r_base;
    w_len_n       = r_len;
    w_wdata_n     = r_wdata;
    w_k_n         = r_k;
    w_buf_n       = r_buf;
    w_if_data_n   = r_if_data;
    w_mem_rdata_n = r_mem_rdata;
    w_if_rdy_n    = 1'b0;
    w_mem_rdy_n   = 1'b0;
    w_ram_a_n     = '0;
    w_ram_wr_n    = 1'b0;
    w_ram_dout_n  = '0;

    case (r_state)
      ST_IDLE: begin
        w_k_n   = '0;
        w_buf_n = '0;
        if (bus.mem_req) begin
          w_owner_mem_n = 1'b1;
          w_base_n      = bus.mem_addr;
          w_len_n       = w_mem_len;
          w_wdata_n     = bus.mem_wdata;
          w_ram_a_n     = bus.mem_addr;
          if (bus.mem_we) begin
            w_state_n    = ST_WRITE;
            w_ram_wr_n   = 1'b1;
            w_ram_dout_n = bus.mem_wdata[7:0];
          end else begin
            w_state_n    = ST_READ;
          end
        end else if (bus.if_req && !bus.if_flush) begin
          w_owner_mem_n = 1'b0;
          w_base_n      = bus.if_addr;
          w_len_n       = 3'd4;
          w_ram_a_n     = bus.if_addr;
          w_state_n     = ST_READ;
        end
      end

      ST_READ: begin
        if (!r_owner_mem && bus.if_flush) begin
          w_state_n = ST_IDLE;
        end else begin
          // RAM data lags the address by one cycle, so step k holds byte k-1
          if (r_k != 3'd0)
            w_buf_n[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
          if (r_k == r_len) begin
            w_state_n = ST_DONE;
            if (r_owner_mem) begin
              w_mem_rdy_n   = 1'b1;
              w_mem_rdata_n = w_buf_n;
            end else begin
              w_if_rdy_n    = 1'b1;
              w_if_data_n   = w_buf_n;
            end
          end else begin
            w_k_n = w_k_inc;
            if (w_k_inc != r_len)
              w_ram_a_n = r_base + {29'd0, w_k_inc};
          end
        end
      end

      ST_WRITE: begin
        if (w_k_inc == r_len) begin
          w_state_n   = ST_DONE;
          w_mem_rdy_n = 1'b1;
        end else begin
          w_k_n        = w_k_inc;
          w_ram_wr_n   = 1'b1;
          w_ram_a_n    = r_base + {29'd0, w_k_inc};
          w_ram_dout_n = r_wdata[{w_k_inc[1:0], 3'b000} +: 8];
        end
      end

      ST_DONE: begin
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner_mem <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_k         <= '0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_if_rdy    <= 1'b0;
      r_mem_rdy   <= 1'b0;
      r_ram_a     <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_owner_mem <= w_owner_mem_n;
      r_base      <= w_base_n;
      r_len       <= w_len_n;
      r_wdata     <= w_wdata_n;
      r_k         <= w_k_n;
      r_buf       <= w_buf_n;
      r_if_data   <= w_if_data_n;
      r_mem_rdata <= w_mem_rdata_n;
      r_if_rdy    <= w_if_rdy_n;
      r_mem_rdy   <= w_mem_rdy_n;
      r_ram_a     <= w_ram_a_n;
      r_ram_wr    <= w_ram_wr_n;
      r_ram_dout  <= w_ram_dout_n;
    end
  end

  assign bus.if_rdy    = r_if_rdy;
  assign bus.if_data   = r_if_data;
  assign bus.mem_rdy   = r_mem_rdy;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.ram_a     = r_ram_a;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_dout  = r_ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0;

  // RAM aliased on address bits [9:0]; every address used below maps uniquely
  logic [7:0]  ram  [0:1023];
  logic        wr_tr[0:1023];
  logic [31:0] a_tr [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a[9:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[9:0]];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // monitor: pops the scoreboard whenever a ready pulse appears
  always @(negedge clk) begin
    exp_t e;
    wr_tr[cyc[9:0]] <= bus.ram_wr;
    a_tr[cyc[9:0]]  <= bus.ram_a;
    if (bus.if_rdy) begin
      chk("if_rdy_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        chk("if_rdy_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_data) chk("if_data", bus.if_data, e.data);
      end
    end
    if (bus.mem_rdy) begin
      chk("mem_rdy_expected", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        chk("mem_rdy_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_data) chk("mem_rdata", bus.mem_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit is_mem, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = is_mem ? bus.mem_rdy : bus.if_rdy;
    end
    chk(is_mem ? "mem_rdy_timeout" : "if_rdy_timeout", 32'(seen), 32'd1);
    if (is_mem) bus.mem_req = 1'b0;
    else        bus.if_req  = 1'b0;
  endtask

  task automatic mem_issue(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.mem_we    = we;
    bus.mem_size  = sz;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_req   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] wr_mask;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = '0;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("rst_outputs_zero",
        {bus.if_rdy, bus.mem_rdy, bus.ram_wr, 29'd0} | bus.ram_a | {24'd0, bus.ram_dout}, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    step();
    rst = 1'b0;

    // IF word read
    ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h10; ram[10'h103] <= 8'h00;
    step(); step();
    t0 = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    if_q.push_back('{32'h00100513, t0 + 6, 1'b1});
    wait_rdy(1'b0, 20);
    step();
    chk("t1_ram_a_c1", a_tr[10'(t0 + 1)], 32'h100);
    chk("t1_ram_a_c4", a_tr[10'(t0 + 4)], 32'h103);

    // simultaneous requests: MEM byte load wins, IF follows
    ram[10'h200] <= 8'hFF;
    step();
    t0 = cyc;
    mem_issue(1'b0, 2'd0, 32'h200, 32'h0);
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    mem_q.push_back('{32'h000000FF, t0 + 3, 1'b1});
    if_q.push_back('{32'h00100513, t0 + 10, 1'b1});
    fork
      wait_rdy(1'b1, 20);
      wait_rdy(1'b0, 30);
    join
    step();
    chk("t2_if_grant_addr", a_tr[10'(t0 + 5)], 32'h100);

    // half store
    ram[10'h010] <= 8'h00; ram[10'h011] <= 8'h00; ram[10'h012] <= 8'h77;
    step();
    t0 = cyc;
    mem_issue(1'b1, 2'd1, 32'h10, 32'hAABBCCDD);
    mem_q.push_back('{32'h0, t0 + 3, 1'b0});
    wait_rdy(1'b1, 20);
    bus.mem_we = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) wr_mask[i] = wr_tr[10'(t0 + i)];
    chk("t3_ram_wr_cycles", {27'd0, wr_mask}, 32'h6);
    chk("t3_ram_10", {24'd0, ram[10'h010]}, 32'hDD);
    chk("t3_ram_11", {24'd0, ram[10'h011]}, 32'hCC);
    chk("t3_ram_12", {24'd0, ram[10'h012]}, 32'h77);

    // flush mid-fetch hands the port to a waiting load
    step();
    t0 = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    step(); step();
    mem_issue(1'b0, 2'd0, 32'h200, 32'h0);
    mem_q.push_back('{32'h000000FF, t0 + 7, 1'b1});
    step();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    step();
    bus.if_flush = 1'b0;
    wait_rdy(1'b1, 20);
    step();
    chk("t4_idle_after_flush", a_tr[10'(t0 + 4)], 32'h0);
    chk("t4_mem_grant_addr", a_tr[10'(t0 + 5)], 32'h200);

    // reset sampled at the end of cycle 1 of a word store
    ram[10'h020] <= 8'h5A; ram[10'h021] <= 8'h5A; ram[10'h022] <= 8'h5A; ram[10'h023] <= 8'h5A;
    step();
    t0 = cyc;
    mem_issue(1'b1, 2'd2, 32'h20, 32'h11223344);
    step();
    rst = 1'b1; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("t5_ram_a", bus.ram_a, 32'd0);
    chk("t5_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    chk("t5_mem_rdy", {31'd0, bus.mem_rdy}, 32'd0);
    chk("t5_mem_rdata", bus.mem_rdata, 32'd0);
    chk("t5_if_data", bus.if_data, 32'd0);
    step(); step(); step();
    chk("t5_ram_20", {24'd0, ram[10'h020]}, 32'h44);
    chk("t5_ram_21", {24'd0, ram[10'h021]}, 32'h5A);
    chk("t5_ram_23", {24'd0, ram[10'h023]}, 32'h5A);

    // word read wrapping past the top of the address space
    ram[10'h3FE] <= 8'hAA; ram[10'h3FF] <= 8'hBB; ram[10'h000] <= 8'hCC; ram[10'h001] <= 8'hDD;
    step();
    t0 = cyc;
    bus.if_addr = 32'hFFFFFFFE; bus.if_req = 1'b1;
    if_q.push_back('{32'hDDCCBBAA, t0 + 6, 1'b1});
    wait_rdy(1'b0, 20);
    step();
    chk("t6_ram_a_c1", a_tr[10'(t0 + 1)], 32'hFFFFFFFE);
    chk("t6_ram_a_c2", a_tr[10'(t0 + 2)], 32'hFFFFFFFF);
    chk("t6_ram_a_c3", a_tr[10'(t0 + 3)], 32'h00000000);
    chk("t6_ram_a_c4", a_tr[10'(t0 + 4)], 32'h00000001);

    // size 3 behaves as a word, then an unaligned half load clears upper bytes
    step();
    t0 = cyc;
    mem_issue(1'b0, 2'd3, 32'h100, 32'h0);
    mem_q.push_back('{32'h00100513, t0 + 6, 1'b1});
    wait_rdy(1'b1, 20);
    step();
    t0 = cyc;
    mem_issue(1'b0, 2'd1, 32'h101, 32'h0);
    mem_q.push_back('{32'h00001005, t0 + 4, 1'b1});
    wait_rdy(1'b1, 20);

    repeat (4) step();
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
